// File: rtl/vc_plru_storage_pkg.sv
// Shared cache definitions for the unified victim cache: address split,
// tag/request/data types and the default victim-cache depth.
package cache_def;

    localparam int TAGMSB_VC      = 31;
    localparam int TAGLSB_VC      = 4;
    localparam int VC_TAG_W       = TAGMSB_VC - TAGLSB_VC + 1;
    localparam int NUM_VC_ENTRIES = 8;
    localparam int CACHE_DATA_W   = 128;

    typedef logic [CACHE_DATA_W-1:0] cache_data_type;

    // {valid, dirty, tag} exactly as stored per line and returned on a hit.
    typedef struct packed {
        logic                     valid;
        logic                     dirty;
        logic [TAGMSB_VC:TAGLSB_VC] tag;
    } vc_cache_tag_type;

    // Controller request; only 'we' reaches the storage (as tag_we_i).
    typedef struct packed {
        logic [31:0]    addr;
        cache_data_type data;
        logic           rw;
        logic           we;
        logic           valid;
    } vc_cache_req_type;

endpackage

// File: rtl/vc_plru_storage_if.sv
// Bundle between the victim cache controller (master) and the storage
// back-end (slave).
//
// Handshake: there is no ready signal; every request is taken in the cycle it
// is presented. lookup_valid_i qualifies lookup_tag_i for that cycle only and
// its result is on tag_read_o/data_read_o/hit_way_o one cycle later. An insert
// is taken only when tag_we_i, data_we_i and lru_valid_i are all high in the
// same cycle. wb_valid_o qualifies wb_tag_o/wb_data_o for exactly one cycle
// and cannot be stalled, so the consumer must take it when it appears.
interface vc_plru_storage_if
    import cache_def::*;
#(
    parameter int NUM_ENTRIES = NUM_VC_ENTRIES,
    parameter int TAG_W       = VC_TAG_W,
    parameter int DATA_W      = CACHE_DATA_W
);
    localparam int WAY_W = $clog2(NUM_ENTRIES);

    logic              lookup_valid_i;
    logic [TAG_W-1:0]  lookup_tag_i;
    logic              tag_we_i;
    logic              data_we_i;
    logic [TAG_W+1:0]  tag_write_i;
    logic [DATA_W-1:0] data_write_i;
    logic              lru_valid_i;
    logic              flush_i;

    logic [TAG_W+1:0]  tag_read_o;
    logic [DATA_W-1:0] data_read_o;
    logic [WAY_W-1:0]  hit_way_o;
    logic              full_o;
    logic              wb_valid_o;
    logic [TAG_W-1:0]  wb_tag_o;
    logic [DATA_W-1:0] wb_data_o;

    modport master (
        output lookup_valid_i, lookup_tag_i, tag_we_i, data_we_i,
               tag_write_i, data_write_i, lru_valid_i, flush_i,
        input  tag_read_o, data_read_o, hit_way_o, full_o,
               wb_valid_o, wb_tag_o, wb_data_o
    );

    modport slave (
        input  lookup_valid_i, lookup_tag_i, tag_we_i, data_we_i,
               tag_write_i, data_write_i, lru_valid_i, flush_i,
        output tag_read_o, data_read_o, hit_way_o, full_o,
               wb_valid_o, wb_tag_o, wb_data_o
    );

endinterface

// File: rtl/vc_plru_storage_plru_tree.sv
// Tree pseudo-LRU state for NUM_ENTRIES ways. Nodes are stored heap-style
// (root 0, children 2n+1 / 2n+2); each bit points toward the LRU half,
// 0 = left (lower way indices). Two touches per cycle are applied in order,
// so the second touched way always ends most-recently-used.
module vc_plru_tree
    import cache_def::*;
#(
    parameter int NUM_ENTRIES = NUM_VC_ENTRIES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           touch_valid,
    input  logic [$clog2(NUM_ENTRIES)-1:0] touch_way,
    input  logic                           touch2_valid,
    input  logic [$clog2(NUM_ENTRIES)-1:0] touch2_way,
    input  logic                           flush,
    output logic [$clog2(NUM_ENTRIES)-1:0] victim_way
);
    localparam int WAY_W = $clog2(NUM_ENTRIES);
    localparam int NODES = NUM_ENTRIES - 1;

    logic [NODES-1:0] tree_q;
    logic [NODES-1:0] tree_d;

    // Walk root to leaf along the way's path, pointing each node away from it.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                               input logic [WAY_W-1:0] way);
        logic [NODES-1:0] r;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] w;
        logic             dir;
        r    = t;
        node = '0;
        w    = way;
        for (int lev = 0; lev < WAY_W; lev++) begin
            dir     = w[WAY_W-1];
            r[node] = ~dir;
            node    = WAY_W'({node, dir}) + WAY_W'(1);
            w       = w << 1;
        end
        return r;
    endfunction

    // Hit-touch first, insert-touch second.
    always_comb begin
        tree_d = tree_q;
        if (touch_valid) begin
            tree_d = touch(tree_d, touch_way);
        end
        if (touch2_valid) begin
            tree_d = touch(tree_d, touch2_way);
        end
    end

    // Tree register; flush wins over any touch in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tree_q <= '0;
        end else if (flush) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

    // Follow the node pointers from the root to the LRU leaf.
    always_comb begin
        logic [WAY_W-1:0] node;
        logic             dir;
        node       = '0;
        victim_way = '0;
        for (int lev = 0; lev < WAY_W; lev++) begin
            dir        = tree_q[node];
            victim_way = WAY_W'({victim_way, dir});
            node       = WAY_W'({node, dir}) + WAY_W'(1);
        end
    end

endmodule

// File: rtl/vc_plru_storage.sv
// Victim cache storage: fully-associative tag/data array with tree-pLRU
// replacement, one-cycle registered lookup, and a one-cycle write-back port
// for dirty lines displaced by an insertion.
module vc_plru_storage
    import cache_def::*;
#(
    parameter int NUM_ENTRIES = NUM_VC_ENTRIES,
    parameter int TAG_W       = VC_TAG_W,
    parameter int DATA_W      = CACHE_DATA_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    vc_plru_storage_if.slave bus
);
    localparam int WAY_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] dirty_q;
    logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];

    logic             wr_valid;
    logic             wr_dirty;
    logic [TAG_W-1:0] wr_tag;

    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;
    logic             mt_hit;
    logic [WAY_W-1:0] mt_way;
    logic             free_any;
    logic [WAY_W-1:0] free_way;
    logic [WAY_W-1:0] victim_way;
    logic [WAY_W-1:0] ins_way;
    logic             ins_en;
    logic             evict;
    logic             hit_touch;

    assign wr_valid = bus.tag_write_i[TAG_W+1];
    assign wr_dirty = bus.tag_write_i[TAG_W];
    assign wr_tag   = bus.tag_write_i[TAG_W-1:0];

    // Lookup compare against every valid way; the insert rule keeps tags unique.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == bus.lookup_tag_i) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(i);
            end
        end
    end

    // Insert way: same tag in place, else lowest free way, else the pLRU victim.
    always_comb begin
        mt_hit   = 1'b0;
        mt_way   = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == wr_tag) begin
                mt_hit = 1'b1;
                mt_way = WAY_W'(i);
            end
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_way = WAY_W'(i);
            end
        end
        ins_en  = bus.tag_we_i & bus.data_we_i & bus.lru_valid_i & ~bus.flush_i;
        ins_way = mt_hit ? mt_way : (free_any ? free_way : victim_way);
        evict   = ins_en & ~mt_hit & ~free_any & dirty_q[victim_way];
    end

    assign hit_touch = bus.lookup_valid_i & lk_hit & ~bus.flush_i;

    vc_plru_tree #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_plru (
        .clk         (clk_i),
        .rst         (rst_i),
        .touch_valid (hit_touch),
        .touch_way   (lk_way),
        .touch2_valid(ins_en),
        .touch2_way  (ins_way),
        .flush       (bus.flush_i),
        .victim_way  (victim_way)
    );

    // Line array: flush drops every line; otherwise write the selected way.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (bus.flush_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (ins_en) begin
            valid_q[ins_way] <= wr_valid;
            dirty_q[ins_way] <= wr_dirty;
            tag_q[ins_way]   <= wr_tag;
            data_q[ins_way]  <= bus.data_write_i;
        end
    end

    // Registered lookup result from the pre-write array; zero when no hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.tag_read_o  <= '0;
            bus.data_read_o <= '0;
            bus.hit_way_o   <= '0;
        end else if (bus.lookup_valid_i && lk_hit) begin
            bus.tag_read_o  <= {1'b1, dirty_q[lk_way], tag_q[lk_way]};
            bus.data_read_o <= data_q[lk_way];
            bus.hit_way_o   <= lk_way;
        end else begin
            bus.tag_read_o  <= '0;
            bus.data_read_o <= '0;
            bus.hit_way_o   <= '0;
        end
    end

    // Write-back capture of a dirty victim; the valid is a single-cycle pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.wb_valid_o <= 1'b0;
            bus.wb_tag_o   <= '0;
            bus.wb_data_o  <= '0;
        end else begin
            bus.wb_valid_o <= evict;
            if (evict) begin
                bus.wb_tag_o  <= tag_q[victim_way];
                bus.wb_data_o <= data_q[victim_way];
            end
        end
    end

    assign bus.full_o = &valid_q;

endmodule

// File: tb/tb_vc_plru_storage.sv
// Bench for vc_plru_storage: directed scenarios plus random traffic, checked
// against a line-level reference model with a per-level pLRU node table.
module tb_vc_plru_storage;
    import cache_def::*;

    localparam int N      = 8;
    localparam int TAG_W  = 28;
    localparam int DATA_W = 128;
    localparam int WAY_W  = 3;

    typedef struct packed {
        logic             chk_rd;
        logic [TAG_W+1:0] tag;
        logic [DATA_W-1:0] data;
        logic [WAY_W-1:0] way;
        logic             full;
    } cyc_exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vc_plru_storage_if #(.NUM_ENTRIES(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    vc_plru_storage #(.NUM_ENTRIES(N), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int fails  = 0;

    cyc_exp_t                  exp_q[$];
    logic [TAG_W+DATA_W-1:0]   wb_q[$];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit                m_valid [N];
    bit                m_dirty [N];
    logic [TAG_W-1:0]  m_tag   [N];
    logic [DATA_W-1:0] m_data  [N];
    bit                m_node  [WAY_W][N];  // [level][path prefix]: 1 = LRU on the right

    cyc_exp_t                pend_e;
    bit                      pend_wb_v;
    logic [TAG_W+DATA_W-1:0] pend_wb;

    function automatic void m_clear_lru();
        for (int l = 0; l < WAY_W; l++)
            for (int p = 0; p < N; p++) m_node[l][p] = 1'b0;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0;
        end
        m_clear_lru();
    endfunction

    function automatic void m_touch(input int way);
        for (int l = 0; l < WAY_W; l++) begin
            int prefix = way >> (WAY_W - l);
            int half   = (way >> (WAY_W - 1 - l)) & 1;
            m_node[l][prefix] = (half == 0);
        end
    endfunction

    function automatic int m_victim();
        int p = 0;
        for (int l = 0; l < WAY_W; l++) p = p * 2 + int'(m_node[l][p]);
        return p;
    endfunction

    task automatic model(input bit lv, input logic [TAG_W-1:0] lt, input bit tw,
                         input bit dw, input bit lru, input vc_cache_tag_type wt,
                         input logic [DATA_W-1:0] wd, input bit fl);
        int hw, vic, way;
        bit ins, all_v;
        hw = -1;
        for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == lt) hw = i;
        pend_e.chk_rd = lv;
        pend_e.tag    = '0;
        pend_e.data   = '0;
        pend_e.way    = '0;
        if (lv && hw >= 0) begin
            pend_e.tag  = {1'b1, m_dirty[hw], m_tag[hw]};
            pend_e.data = m_data[hw];
            pend_e.way  = WAY_W'(hw);
        end
        pend_wb_v = 0;
        pend_wb   = '0;
        vic = m_victim();
        ins = tw && dw && lru && !fl;
        way = -1;
        if (ins) begin
            for (int i = 0; i < N; i++) if (way < 0 && m_valid[i] && m_tag[i] == wt.tag) way = i;
            for (int i = 0; i < N; i++) if (way < 0 && !m_valid[i]) way = i;
            if (way < 0) begin
                way = vic;
                if (m_dirty[vic]) begin
                    pend_wb_v = 1;
                    pend_wb   = {m_tag[vic], m_data[vic]};
                end
            end
        end
        if (lv && hw >= 0 && !fl) m_touch(hw);
        if (ins) begin
            m_touch(way);
            m_valid[way] = wt.valid;
            m_dirty[way] = wt.dirty;
            m_tag[way]   = wt.tag;
            m_data[way]  = wd;
        end
        if (fl) begin
            for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
            m_clear_lru();
        end
        all_v = 1;
        for (int i = 0; i < N; i++) all_v &= m_valid[i];
        pend_e.full = all_v;
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic vc_cache_tag_type mk_tag(input logic [TAG_W-1:0] t, input bit d);
        vc_cache_tag_type r;
        r.valid = 1'b1;
        r.dirty = d;
        r.tag   = t;
        return r;
    endfunction

    task automatic step(input bit lv, input logic [TAG_W-1:0] lt, input bit tw,
                        input bit dw, input bit lru, input vc_cache_tag_type wt,
                        input logic [DATA_W-1:0] wd, input bit fl);
        bus.lookup_valid_i = lv;
        bus.lookup_tag_i   = lt;
        bus.tag_we_i       = tw;
        bus.data_we_i      = dw;
        bus.lru_valid_i    = lru;
        bus.tag_write_i    = wt;
        bus.data_write_i   = wd;
        bus.flush_i        = fl;
        model(lv, lt, tw, dw, lru, wt, wd, fl);
        @(posedge clk);
        #1;
        exp_q.push_back(pend_e);
        if (pend_wb_v) wb_q.push_back(pend_wb);
    endtask

    task automatic do_idle();
        step(0, '0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic do_lookup(input logic [TAG_W-1:0] t);
        step(1, t, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic do_insert(input logic [TAG_W-1:0] t, input bit d, input logic [DATA_W-1:0] dat);
        step(0, '0, 1, 1, 1, mk_tag(t, d), dat, 0);
    endtask

    task automatic chk_all_zero(input string where);
        check({where, "_tag_read"},  DATA_W'(bus.tag_read_o), '0);
        check({where, "_data_read"}, bus.data_read_o, '0);
        check({where, "_hit_way"},   DATA_W'(bus.hit_way_o), '0);
        check({where, "_full"},      DATA_W'(bus.full_o), '0);
        check({where, "_wb_valid"},  DATA_W'(bus.wb_valid_o), '0);
        check({where, "_wb_tag"},    DATA_W'(bus.wb_tag_o), '0);
        check({where, "_wb_data"},   bus.wb_data_o, '0);
    endtask

    // ---------------- scoreboard monitor ----------------
    cyc_exp_t                me;
    logic [TAG_W+DATA_W-1:0] mw;
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                if (me.chk_rd) begin
                    check("tag_read", DATA_W'(bus.tag_read_o), DATA_W'(me.tag));
                    check("data_read", bus.data_read_o, me.data);
                    if (me.tag[TAG_W+1]) check("hit_way", DATA_W'(bus.hit_way_o), DATA_W'(me.way));
                end
                check("full", DATA_W'(bus.full_o), DATA_W'(me.full));
            end
            if (bus.wb_valid_o) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL wb_unexpected: got wb_valid=1 tag %h, required no write-back", bus.wb_tag_o);
                end else begin
                    mw = wb_q.pop_front();
                    check("wb_tag", DATA_W'(bus.wb_tag_o), DATA_W'(mw[TAG_W+DATA_W-1:DATA_W]));
                    check("wb_data", bus.wb_data_o, mw[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.lookup_valid_i = 0; bus.lookup_tag_i = '0; bus.tag_we_i = 0; bus.data_we_i = 0;
        bus.lru_valid_i = 0; bus.tag_write_i = '0; bus.data_write_i = '0; bus.flush_i = 0;
        m_reset();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Clean fills land in ways 0..7, full rises after the last one.
        for (int i = 0; i < N; i++) do_insert(TAG_W'(32'h10 + i), 0, rnd_data());
        do_lookup(TAG_W'(32'h13));
        do_lookup(TAG_W'(32'h99));
        do_idle();

        // Make every line dirty in place, then displace the pLRU victim.
        for (int i = 0; i < N; i++) do_insert(TAG_W'(32'h10 + i), 1, rnd_data());
        do_insert(TAG_W'(32'h20), 1, rnd_data());
        do_idle();
        do_lookup(TAG_W'(32'h11));
        do_insert(TAG_W'(32'h21), 1, rnd_data());
        do_idle();

        // In-place overwrite of an existing tag.
        do_insert(TAG_W'(32'h15), 1, rnd_data());
        do_lookup(TAG_W'(32'h15));

        // Lookup and insert in the same cycle.
        step(1, TAG_W'(32'h14), 1, 1, 1, mk_tag(TAG_W'(32'h30), 1), rnd_data(), 0);
        do_lookup(TAG_W'(32'h30));
        do_lookup(TAG_W'(32'h14));

        // Partial strobe combinations are ignored.
        step(0, '0, 1, 1, 0, mk_tag(TAG_W'(32'h77), 1), rnd_data(), 0);
        step(0, '0, 1, 0, 1, mk_tag(TAG_W'(32'h77), 1), rnd_data(), 0);
        step(0, '0, 0, 1, 1, mk_tag(TAG_W'(32'h77), 1), rnd_data(), 0);
        do_lookup(TAG_W'(32'h77));

        // Random traffic over a tag pool larger than the array.
        for (int c = 0; c < 400; c++) begin
            bit lv, tw, dw, lru, fl, ins_try;
            lv      = ($urandom_range(0, 1) == 1);
            ins_try = ($urandom_range(0, 1) == 1);
            tw  = ins_try && ($urandom_range(0, 9) != 0);
            dw  = ins_try && ($urandom_range(0, 9) != 0);
            lru = ins_try && ($urandom_range(0, 9) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            step(lv, TAG_W'(32'h10 + $urandom_range(0, 11)), tw, dw, lru,
                 mk_tag(TAG_W'(32'h10 + $urandom_range(0, 11)), $urandom_range(0, 1) == 1),
                 rnd_data(), fl);
        end

        // Flush mid-stream: same-cycle lookup still sees old contents.
        for (int i = 0; i < N; i++) do_insert(TAG_W'(32'h50 + i), 1, rnd_data());
        step(1, TAG_W'(32'h52), 1, 1, 1, mk_tag(TAG_W'(32'h60), 1), rnd_data(), 1);
        do_lookup(TAG_W'(32'h52));
        do_lookup(TAG_W'(32'h57));
        do_insert(TAG_W'(32'h61), 0, rnd_data());
        do_lookup(TAG_W'(32'h61));

        // Asynchronous reset between edges with a full, dirty array.
        for (int i = 0; i < N; i++) do_insert(TAG_W'(32'h40 + i), 1, rnd_data());
        do_insert(TAG_W'(32'h48), 1, rnd_data());
        #2;
        rst = 1;
        exp_q.delete();
        wb_q.delete();
        m_reset();
        #1;
        chk_all_zero("midrst");
        #3;
        rst = 0;
        do_lookup(TAG_W'(32'h40));
        do_lookup(TAG_W'(32'h47));
        do_insert(TAG_W'(32'h42), 0, rnd_data());
        do_lookup(TAG_W'(32'h42));
        do_idle();
        do_idle();

        @(negedge clk);
        #1;
        check("exp_q_drained", DATA_W'(exp_q.size()), '0);
        check("wb_q_drained", DATA_W'(wb_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
